// File: rtl/ram_pair_reader.sv
// Read-side client for the interpolation RAM: walks a region two words per cycle
// and streams registered word pairs downstream over a valid/ready handshake.
module ram_pair_reader #(
  parameter int ADDRESS_WIDTH = 13,
  parameter int DATA_WIDTH    = 64,
  parameter int COUNT_WIDTH   = 12
) (
  input  logic                     CLK,
  input  logic                     RST_n,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] base_addr,
  input  logic [COUNT_WIDTH-1:0]   pair_count,
  output logic                     busy,
  output logic                     done,
  output logic [ADDRESS_WIDTH-1:0] address_RD1,
  output logic [ADDRESS_WIDTH-1:0] address_RD2,
  input  logic [DATA_WIDTH-1:0]    dataIn1,
  input  logic [DATA_WIDTH-1:0]    dataIn2,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_data1,
  output logic [DATA_WIDTH-1:0]    out_data2,
  output logic [COUNT_WIDTH-1:0]   out_index
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                   state;
  logic [ADDRESS_WIDTH-1:0] base;
  logic [ADDRESS_WIDTH-1:0] offset;
  logic [COUNT_WIDTH-1:0]   count;
  logic [COUNT_WIDTH-1:0]   idx;
  logic                     load;
  logic                     last;

  // 2*idx is formed at address width so wrap past the top of the RAM is silent
  assign offset      = ADDRESS_WIDTH'(idx) << 1;
  assign address_RD1 = base + offset;
  assign address_RD2 = address_RD1 + ADDRESS_WIDTH'(1);

  assign load = (state == RUN) && (!out_valid || out_ready);
  assign last = (idx == count - COUNT_WIDTH'(1));
  assign busy = (state != IDLE);

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state     <= IDLE;
      base      <= '0;
      count     <= '0;
      idx       <= '0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_data1 <= '0;
      out_data2 <= '0;
      out_index <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (pair_count != '0) begin
              base  <= base_addr;
              count <= pair_count;
              idx   <= '0;
              state <= RUN;
            end else begin
              done <= 1'b1;
            end
          end
        end
        RUN: begin
          if (load) begin
            out_data1 <= dataIn1;
            out_data2 <= dataIn2;
            out_index <= idx;
            out_valid <= 1'b1;
            idx       <= idx + COUNT_WIDTH'(1);
            if (last) state <= DRAIN;
          end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
          end
        end
        DRAIN: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            done      <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_pair_reader.sv
// Directed bench for ram_pair_reader with a behavioural RAM holding word[a]=a.
module tb_ram_pair_reader;

  localparam int AW = 13;
  localparam int DW = 64;
  localparam int CW = 12;

  logic          CLK;
  logic          RST_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [CW-1:0] pair_count;
  logic          busy;
  logic          done;
  logic [AW-1:0] address_RD1;
  logic [AW-1:0] address_RD2;
  logic [DW-1:0] dataIn1;
  logic [DW-1:0] dataIn2;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data1;
  logic [DW-1:0] out_data2;
  logic [CW-1:0] out_index;

  logic [DW-1:0] ram [0:8191];
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic          dead_active;

  int n_checks;
  int n_fail;

  typedef struct {
    logic [AW-1:0] base;
    logic [CW-1:0] count;
    logic [3:0]    pat;
    logic [DW-1:0] f1, f2, l1, l2;
    int            busy_cycles;
  } vec_t;

  vec_t vecs [5];

  ram_pair_reader #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
    .CLK(CLK), .RST_n(RST_n), .start(start), .base_addr(base_addr),
    .pair_count(pair_count), .busy(busy), .done(done),
    .address_RD1(address_RD1), .address_RD2(address_RD2),
    .dataIn1(dataIn1), .dataIn2(dataIn2), .out_valid(out_valid),
    .out_ready(out_ready), .out_data1(out_data1), .out_data2(out_data2),
    .out_index(out_index)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  assign dataIn1 = ram[address_RD1];
  assign dataIn2 = ram[address_RD2];

  always @(posedge CLK) begin
    if (we) ram[waddr] <= wdata;
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_word(input logic [AW-1:0] a);
    return (dead_active && a == AW'(18)) ? DW'(64'hDEAD) : DW'(a);
  endfunction

  // Starts a run, then per cycle applies out_ready from pat and checks the presented pair.
  task automatic run_check(input string tag, input logic [AW-1:0] b, input logic [CW-1:0] n,
                           input logic [3:0] pat, input int wr_cycle,
                           input logic [DW-1:0] f1, input logic [DW-1:0] f2,
                           input logic [DW-1:0] l1, input logic [DW-1:0] l2,
                           input int busy_exp);
    int beat;
    int c;
    int busy_cyc;
    logic [AW-1:0] a;
    @(negedge CLK);
    start = 1'b1; base_addr = b; pair_count = n;
    @(negedge CLK);
    start = 1'b0;
    beat = 0; c = 0; busy_cyc = 0;
    while (beat < int'(n) && c < 200) begin
      out_ready = pat[c % 4];
      we = (c == wr_cycle);
      if (busy) busy_cyc++;
      if (c == 0) chk({tag, " latency valid"}, DW'(out_valid), '0);
      chk({tag, " no early done"}, DW'(done), '0);
      if (out_valid) begin
        a = b + AW'(2 * beat);
        chk({tag, " index"}, DW'(out_index), DW'(beat));
        chk({tag, " data1"}, out_data1, exp_word(a));
        chk({tag, " data2"}, out_data2, exp_word(a + AW'(1)));
        if (out_ready) begin
          if (beat == 0) begin
            chk({tag, " first1"}, out_data1, f1);
            chk({tag, " first2"}, out_data2, f2);
          end
          if (beat == int'(n) - 1) begin
            chk({tag, " last1"}, out_data1, l1);
            chk({tag, " last2"}, out_data2, l2);
          end
          beat++;
        end
      end
      @(negedge CLK);
      c++;
    end
    we = 1'b0;
    chk({tag, " beats accepted"}, DW'(beat), DW'(n));
    chk({tag, " done pulse"}, DW'(done), 64'd1);
    chk({tag, " busy low at done"}, DW'(busy), '0);
    chk({tag, " valid low at done"}, DW'(out_valid), '0);
    chk({tag, " busy cycles"}, DW'(busy_cyc), DW'(busy_exp));
    @(negedge CLK);
    chk({tag, " done one cycle"}, DW'(done), '0);
    out_ready = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_fail = 0; dead_active = 1'b0;
    RST_n = 1'b0; start = 1'b0; base_addr = '0; pair_count = '0;
    out_ready = 1'b0; we = 1'b0; waddr = AW'(18); wdata = DW'(64'hDEAD);
    for (int a = 0; a < 8192; a++) ram[a] <= DW'(a);

    vecs[0] = '{13'd16,   12'd4, 4'b1111, 64'd16,   64'd17,   64'd22,   64'd23, 5};
    vecs[1] = '{13'd16,   12'd4, 4'b1001, 64'd16,   64'd17,   64'd22,   64'd23, 9};
    vecs[2] = '{13'd8190, 12'd2, 4'b1111, 64'd8190, 64'd8191, 64'd0,    64'd1,  3};
    vecs[3] = '{13'd8191, 12'd1, 4'b1111, 64'd8191, 64'd0,    64'd8191, 64'd0,  2};
    vecs[4] = '{13'd100,  12'd3, 4'b0101, 64'd100,  64'd101,  64'd104,  64'd105, 7};

    @(negedge CLK);
    chk("reset busy", DW'(busy), '0);
    chk("reset done", DW'(done), '0);
    chk("reset valid", DW'(out_valid), '0);
    chk("reset rd1", DW'(address_RD1), '0);
    chk("reset rd2", DW'(address_RD2), 64'd1);
    chk("reset index", DW'(out_index), '0);
    RST_n = 1'b1;

    for (int unsigned i = 0; i < 5; i++)
      run_check($sformatf("vec%0d", i), vecs[i].base, vecs[i].count, vecs[i].pat, -1,
                vecs[i].f1, vecs[i].f2, vecs[i].l1, vecs[i].l2, vecs[i].busy_cycles);

    // zero-length request: done only, no beats
    @(negedge CLK);
    start = 1'b1; base_addr = AW'(50); pair_count = '0;
    @(negedge CLK);
    start = 1'b0;
    chk("zero done", DW'(done), 64'd1);
    chk("zero busy", DW'(busy), '0);
    chk("zero valid", DW'(out_valid), '0);
    @(negedge CLK);
    chk("zero done once", DW'(done), '0);
    chk("zero busy after", DW'(busy), '0);

    // asynchronous abort after the second pair is presented
    out_ready = 1'b1;
    start = 1'b1; base_addr = AW'(200); pair_count = CW'(10);
    @(negedge CLK);
    start = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    chk("abort pair1 index", DW'(out_index), 64'd1);
    #1 RST_n = 1'b0;
    #1;
    chk("abort busy", DW'(busy), '0);
    chk("abort valid", DW'(out_valid), '0);
    chk("abort done", DW'(done), '0);
    chk("abort data1", out_data1, '0);
    chk("abort data2", out_data2, '0);
    chk("abort index", DW'(out_index), '0);
    chk("abort rd1", DW'(address_RD1), '0);
    chk("abort rd2", DW'(address_RD2), 64'd1);
    @(negedge CLK);
    RST_n = 1'b1;
    out_ready = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("abort no done", DW'(done), '0);
    end
    run_check("after abort", AW'(40), CW'(2), 4'b1111, -1,
              64'd40, 64'd41, 64'd42, 64'd43, 3);

    // write to address 18 on the edge that captures pair 1: old value seen
    run_check("collide", AW'(16), CW'(4), 4'b1111, 1,
              64'd16, 64'd17, 64'd22, 64'd23, 5);
    dead_active = 1'b1;
    run_check("post write", AW'(16), CW'(4), 4'b1111, -1,
              64'd16, 64'd17, 64'd22, 64'd23, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
